// File: rtl/alp_cmd_scheduler.sv
// Round-robin front end that shares one ALP datapath between two requesters and
// sequences LOAD/COMP/CLR strobes. Optional perf counters: define ALP_SCHED_PERF_EN.
module alp_cmd_scheduler #(
    parameter int         W           = 4,
    parameter logic [2:0] MUL_END     = 3'd5,
    parameter int         MUL_TIMEOUT = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_clr,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_clr,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic         alp_load,
    output logic         alp_comp,
    output logic         alp_clr,
    output logic [2:0]   alp_op,
    output logic [W-1:0] alp_data,
    input  logic [2:0]   alp_mul_state,
    input  logic [W-1:0] alp_result,
`ifdef ALP_SCHED_PERF_EN
    output logic         busy,
    output logic [15:0]  perf_ops,
    output logic [15:0]  perf_mul_cyc
`else
    output logic         busy
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMP,
        S_CAPT,
        S_CLRS,
        S_RESP
    } state_t;

    localparam logic [2:0]    OP_MUL   = 3'b010;
    localparam int            CW       = $clog2(MUL_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          last_id;      // 1 when req1 won the most recent grant
    logic          cur_id;
    logic          cur_err;
    logic [2:0]    cur_op;
    logic [W-1:0]  cur_data;
    logic [CW-1:0] comp_cnt;
    logic          mul_end_seen;
    logic          mul_end_hit;
    logic          mul_timeout;
    logic          grant0;
    logic          grant1;
    logic          grant_any;
    logic          is_mul;

    assign is_mul     = (cur_op == OP_MUL);
    assign grant_any  = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign alp_op     = cur_op;
    assign alp_data   = cur_data;

    // With both requesters valid, the one not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_id;
                grant1 = ~last_id;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt   = state;
        alp_load    = 1'b0;
        alp_comp    = 1'b0;
        alp_clr     = 1'b0;
        mul_end_hit = 1'b0;
        mul_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    state_nxt = (grant1 ? req1_clr : req0_clr) ? S_CLRS : S_LOAD;
                end
            end
            S_LOAD: begin
                alp_load  = 1'b1;
                state_nxt = S_COMP;
            end
            S_COMP: begin
                alp_comp = 1'b1;
                if (!is_mul || mul_end_seen) begin
                    state_nxt = S_CAPT;
                end else if (alp_mul_state == MUL_END) begin
                    // Stay one more COMP cycle so the ALP writes R0/R1.
                    mul_end_hit = 1'b1;
                end else if (comp_cnt == CNT_LAST) begin
                    mul_timeout = 1'b1;
                    state_nxt   = S_CLRS;
                end
            end
            S_CAPT: begin
                state_nxt = S_RESP;
            end
            S_CLRS: begin
                alp_clr   = 1'b1;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id      <= 1'b1;
            cur_id       <= 1'b0;
            cur_err      <= 1'b0;
            cur_op       <= '0;
            cur_data     <= '0;
            comp_cnt     <= '0;
            mul_end_seen <= 1'b0;
        end else if (grant_any) begin
            last_id      <= grant1;
            cur_id       <= grant1;
            cur_err      <= 1'b0;
            cur_op       <= grant1 ? req1_op : req0_op;
            cur_data     <= grant1 ? req1_data : req0_data;
            comp_cnt     <= '0;
            mul_end_seen <= 1'b0;
        end else if (state == S_COMP) begin
            comp_cnt <= comp_cnt + CW'(1);
            if (mul_end_hit) begin
                mul_end_seen <= 1'b1;
            end
            if (mul_timeout) begin
                cur_err <= 1'b1;
            end
        end
    end

    // Response fields are loaded once and held stable for the whole RESP state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (state == S_CAPT) begin
            rsp_id   <= cur_id;
            rsp_data <= alp_result;
            rsp_err  <= 1'b0;
        end else if (state == S_CLRS) begin
            rsp_id   <= cur_id;
            rsp_data <= '0;
            rsp_err  <= cur_err;
        end
    end

`ifdef ALP_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops     <= '0;
            perf_mul_cyc <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (perf_ops != 16'hFFFF)) begin
                perf_ops <= perf_ops + 16'd1;
            end
            if ((state == S_COMP) && is_mul && (perf_mul_cyc != 16'hFFFF)) begin
                perf_mul_cyc <= perf_mul_cyc + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alp_cmd_scheduler.sv
// Directed self-checking bench for alp_cmd_scheduler with a small Booth-sequencer
// model driving alp_mul_state.
module tb_alp_cmd_scheduler;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req0_clr = 1'b0;
    logic [2:0]   req0_op = '0;
    logic [W-1:0] req0_data = '0;
    logic         req1_valid = 1'b0, req1_clr = 1'b0;
    logic [2:0]   req1_op = '0;
    logic [W-1:0] req1_data = '0;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] alp_result = '0;
    logic [2:0]   alp_mul_state;
    logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
    logic [W-1:0] rsp_data, alp_data;
    logic         alp_load, alp_comp, alp_clr, busy;
    logic [2:0]   alp_op;
`ifdef ALP_SCHED_PERF_EN
    logic [15:0]  perf_ops, perf_mul_cyc;
`endif

    alp_cmd_scheduler #(.W(W), .MUL_END(3'd5), .MUL_TIMEOUT(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_clr(req0_clr),
        .req0_op(req0_op), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_clr(req1_clr),
        .req1_op(req1_op), .req1_data(req1_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alp_load(alp_load), .alp_comp(alp_comp), .alp_clr(alp_clr),
        .alp_op(alp_op), .alp_data(alp_data),
        .alp_mul_state(alp_mul_state), .alp_result(alp_result),
`ifdef ALP_SCHED_PERF_EN
        .busy(busy), .perf_ops(perf_ops), .perf_mul_cyc(perf_mul_cyc)
`else
        .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    // Booth sequencer model: reports end state on the 10th consecutive COMP cycle.
    int   mcnt;
    logic mul_stuck = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        mcnt <= 0;
        else if (alp_comp) mcnt <= mcnt + 1;
        else               mcnt <= 0;
    end
    assign alp_mul_state = (!mul_stuck && mcnt >= 9) ? 3'd5 : 3'd2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int         n_grant, n_load, n_comp, n_clr, n_multi, lat, ld_cyc, cp_cyc;
    logic [2:0] ld_op;
    logic [3:0] ld_data;

    // Issues one command and observes until rsp_valid (rsp_ready held low).
    task automatic do_op(input string tag, input bit id, input logic clr,
                         input logic [2:0] op, input logic [3:0] d);
        int  gcyc = -1;
        bit  g;
        bit  done = 1'b0;
        n_grant = 0; n_load = 0; n_comp = 0; n_clr = 0; n_multi = 0;
        lat = -1; ld_cyc = -1; cp_cyc = -1; ld_op = 'x; ld_data = 'x;
        rsp_ready = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_clr = clr; req1_op = op; req1_data = d;
        end else begin
            req0_valid = 1'b1; req0_clr = clr; req0_op = op; req0_data = d;
        end
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            g = id ? req1_ready : req0_ready;
            if (g) begin
                n_grant++;
                if (gcyc < 0) gcyc = c;
            end
            if (alp_load) begin
                n_load++; ld_op = alp_op; ld_data = alp_data;
                if (ld_cyc < 0) ld_cyc = c - gcyc;
            end
            if (alp_comp) begin
                n_comp++;
                if (cp_cyc < 0) cp_cyc = c - gcyc;
            end
            if (alp_clr) n_clr++;
            if (int'(alp_load) + int'(alp_comp) + int'(alp_clr) > 1) n_multi++;
            if (rsp_valid) begin
                done = 1'b1;
                lat  = c - gcyc;
            end else begin
                step();
                if (g) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic accept(input string tag);
        rsp_ready = 1'b1;
        step();
        #1;
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int         n0, n1, first, nrsp, bad;
        logic [1:0] ids;
        bit         g0, g1;
        logic [3:0] h_data;
        logic       h_id, h_err;

        // Reset state
        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_strobes", {29'd0, alp_load, alp_comp, alp_clr}, 32'd0);
        check("rst_alp_op", 32'(alp_op), 32'd0);
        check("rst_alp_data", 32'(alp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Both requesters valid: req0 first, then req1, one ready pulse each
        n0 = 0; n1 = 0; first = -1; nrsp = 0; ids = '0;
        rsp_ready = 1'b1; alp_result = 4'h9;
        req0_valid = 1'b1; req0_clr = 1'b0; req0_op = 3'b000; req0_data = 4'h1;
        req1_valid = 1'b1; req1_clr = 1'b0; req1_op = 3'b001; req1_data = 4'h2;
        for (int c = 0; c < 20; c++) begin
            #1;
            g0 = req0_ready; g1 = req1_ready;
            if (g0) begin n0++; if (first < 0) first = 0; end
            if (g1) begin n1++; if (first < 0) first = 1; end
            if (rsp_valid) begin
                if (nrsp < 2) ids[nrsp] = rsp_id;
                nrsp++;
            end
            step();
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
        end
        check("rr_first", 32'(first), 32'd0);
        check("rr_pulses0", 32'(n0), 32'd1);
        check("rr_pulses1", 32'(n1), 32'd1);
        check("rr_nrsp", 32'(nrsp), 32'd2);
        check("rr_ids", 32'(ids), 32'b10);
        rsp_ready = 1'b0;

        // Plain op: grant c0, load c1, single comp c2, rsp_valid c4
        alp_result = 4'h6;
        do_op("t1", 1'b0, 1'b0, 3'b000, 4'h3);
        check("t1_lat", 32'(lat), 32'd4);
        check("t1_load_cyc", 32'(ld_cyc), 32'd1);
        check("t1_comp_cyc", 32'(cp_cyc), 32'd2);
        check("t1_n_comp", 32'(n_comp), 32'd1);
        check("t1_ld_data", 32'(ld_data), 32'h3);
        check("t1_ld_op", 32'(ld_op), 32'd0);
        check("t1_rsp", {27'd0, rsp_id, rsp_err, rsp_data}, {27'd0, 1'b0, 1'b0, 4'h6});
        accept("t1");

        // Multiply completes: end state on 10th COMP cycle, COMP high 11 cycles
        alp_result = 4'hC;
        do_op("t3", 1'b1, 1'b0, 3'b010, 4'h7);
        check("t3_grant", 32'(n_grant), 32'd1);
        check("t3_n_comp", 32'(n_comp), 32'd11);
        check("t3_n_load", 32'(n_load), 32'd1);
        check("t3_n_clr", 32'(n_clr), 32'd0);
        check("t3_lat", 32'(lat), 32'd14);
        check("t3_onehot", 32'(n_multi), 32'd0);
        check("t3_rsp", {27'd0, rsp_id, rsp_err, rsp_data}, {27'd0, 1'b1, 1'b0, 4'hC});
        accept("t3");

        // Multiply timeout: 24 COMP cycles, one CLR, error response
        mul_stuck = 1'b1;
        do_op("t4", 1'b0, 1'b0, 3'b010, 4'h5);
        check("t4_n_comp", 32'(n_comp), 32'd24);
        check("t4_n_clr", 32'(n_clr), 32'd1);
        check("t4_lat", 32'(lat), 32'd27);
        check("t4_onehot", 32'(n_multi), 32'd0);
        check("t4_rsp", {27'd0, rsp_id, rsp_err, rsp_data}, {27'd0, 1'b0, 1'b1, 4'h0});
        accept("t4");
        mul_stuck = 1'b0;

        // CLR command, then response held for 5 cycles with another request waiting
        alp_result = 4'hF;
        do_op("t5", 1'b0, 1'b1, 3'b011, 4'hA);
        check("t5_n_clr", 32'(n_clr), 32'd1);
        check("t5_no_ld_comp", 32'(n_load + n_comp), 32'd0);
        check("t5_lat", 32'(lat), 32'd2);
        check("t5_rsp", {27'd0, rsp_id, rsp_err, rsp_data}, {27'd0, 1'b0, 1'b0, 4'h0});
        h_id = rsp_id; h_err = rsp_err; h_data = rsp_data;
        req1_valid = 1'b1; req1_clr = 1'b1; req1_op = 3'b000; req1_data = 4'h0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            #1;
            if (rsp_valid !== 1'b1 || rsp_id !== h_id || rsp_err !== h_err ||
                rsp_data !== h_data || req1_ready !== 1'b0) bad++;
        end
        check("t5_hold", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        #1;
        check("t5_no_grant_in_resp", 32'(req1_ready), 32'd0);
        step();
        #1;
        check("t5_rsp_drop", 32'(rsp_valid), 32'd0);
        check("t5_next_grant", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        repeat (4) step();
        check("t5_back_idle", 32'(busy), 32'd0);
        rsp_ready = 1'b0;

        // Reset during multiply COMP
        mul_stuck = 1'b1;
        req0_valid = 1'b1; req0_clr = 1'b0; req0_op = 3'b010; req0_data = 4'h4;
        #1;
        check("t6_grant", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        step();
        step();
        check("t6_in_comp", 32'(alp_comp), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_strobes", {29'd0, alp_load, alp_comp, alp_clr}, 32'd0);
        check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        mul_stuck = 1'b0;
        step();
        check("t6_idle", 32'(busy), 32'd0);
        req0_valid = 1'b1; req0_op = 3'b000; req1_valid = 1'b1; req1_clr = 1'b0;
        #1;
        check("t6_favour_req0", {30'd0, req1_ready, req0_ready}, 32'b01);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
